// File: rtl/dmem_if.sv
// Load/store port between the core's initiator and the data-memory responder.
// Request channel and response channel each use a valid/ready handshake.
interface dmem_if #(
  parameter int unsigned ADDR_W = 32
) ();
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic [3:0]        req_be;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding request, WAIT_CYCLES of latency, byte-enabled stores.
// Optional macro DMEM_MISALIGN_ERR_EN flags req_addr[1:0] != 0 as an access error.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned ADDR_W      = 32
) (
  input  logic   clk,
  input  logic   reset,
  dmem_if.slave  bus,
  output logic   busy_o
);

  localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned WA_W  = ADDR_W - 2;
  localparam int unsigned CNT_W = 4;

`ifdef DMEM_MISALIGN_ERR_EN
  localparam bit MISALIGN_EN = 1'b1;
`else
  localparam bit MISALIGN_EN = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e            state_q,     state_d;
  logic [CNT_W-1:0]  cnt_q,       cnt_d;
  logic              we_q,        we_d;
  logic [WA_W-1:0]   waddr_q,     waddr_d;
  logic              mis_q,       mis_d;
  logic [31:0]       wdata_q,     wdata_d;
  logic [3:0]        be_q,        be_d;
  logic [31:0]       rdata_q,     rdata_d;
  logic              err_q,       err_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              req_ready_q, req_ready_d;
  logic              busy_q,      busy_d;

  logic [31:0]       mem_q [DEPTH_WORDS];
  logic              wr_en_c;
  logic              err_c;
  logic [IDX_W-1:0]  idx_c;

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
  assign busy_o        = busy_q;

  // State and datapath registers; storage itself is never reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      waddr_q     <= '0;
      mis_q       <= 1'b0;
      wdata_q     <= '0;
      be_q        <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      req_ready_q <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      waddr_q     <= waddr_d;
      mis_q       <= mis_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      rsp_valid_q <= rsp_valid_d;
      req_ready_q <= req_ready_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state, capture and access decode
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    waddr_d = waddr_q;
    mis_d   = mis_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    wr_en_c = 1'b0;

    idx_c = waddr_q[IDX_W-1:0];
    err_c = (waddr_q >= WA_W'(DEPTH_WORDS)) | (MISALIGN_EN & mis_q);

    unique case (state_q)
      S_IDLE: begin
        if (bus.req_valid && req_ready_q) begin
          we_d    = bus.req_we;
          waddr_d = bus.req_addr[ADDR_W-1:2];
          mis_d   = |bus.req_addr[1:0];
          wdata_d = bus.req_wdata;
          be_d    = bus.req_be;
          cnt_d   = CNT_W'(WAIT_CYCLES);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          err_d   = err_c;
          rdata_d = (we_q || err_c) ? 32'h0 : mem_q[idx_c];
          wr_en_c = we_q && !err_c;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    req_ready_d = (state_d == S_IDLE);
    rsp_valid_d = (state_d == S_RESP);
    busy_d      = (state_d != S_IDLE);
  end

  // Byte-lane store at the access edge
  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      for (int i = 0; i < 4; i++) begin
        if (be_q[i]) mem_q[idx_c][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: directed requests push expected responses,
// a monitor pops and compares on every response handshake.
module tb_dmem_responder;

  localparam int unsigned WAIT  = 2;
  localparam int unsigned DEPTH = 64;

  logic clk;
  logic reset;
  logic busy;

  dmem_if #(.ADDR_W(32)) bus ();

  dmem_responder #(
    .DEPTH_WORDS (DEPTH),
    .WAIT_CYCLES (WAIT),
    .ADDR_W      (32)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .bus    (bus),
    .busy_o (busy)
  );

  typedef struct {
    logic [31:0] rd;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_pass   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Response monitor: the handshake completes on the next rising edge
  always @(negedge clk) begin
    if (bus.rsp_valid && bus.rsp_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL rsp_unexpected: got rdata %h err %0d with empty scoreboard",
                 bus.rsp_rdata, bus.rsp_err);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rsp_rdata", bus.rsp_rdata, mon_e.rd);
        chk("rsp_err", 32'(bus.rsp_err), 32'(mon_e.err));
      end
    end
  end

  // Present a request and return at 1ns after the accepting edge
  task automatic present(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, input string nm);
    bit acc;
    acc = 0;
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_be    = be;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.req_ready) begin
        acc = 1;
        break;
      end
    end
    chk({nm, "_accepted"}, 32'(acc), 32'd1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  // Wait for rsp_valid after an accept; latency counted in rising edges
  task automatic wait_rsp(input string nm);
    int k;
    k = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (bus.rsp_valid) begin
        k = i;
        break;
      end
    end
    chk({nm, "_latency"}, 32'(k), 32'(WAIT + 1));
  endtask

  task automatic drain(input string nm);
    for (int i = 0; i < 50 && bus.rsp_valid; i++) begin
      @(posedge clk); #1;
    end
    chk({nm, "_drained"}, 32'(bus.rsp_valid), 32'd0);
  endtask

  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input logic [31:0] exp_rd, input logic exp_err,
                        input string nm);
    present(we, addr, wdata, be, nm);
    exp_q.push_back('{rd: exp_rd, err: exp_err});
    wait_rsp(nm);
    drain(nm);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset         = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_be    = '0;
    bus.rsp_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);

    // Full-word store then load
    do_req(1'b1, 32'h54, 32'hDEADBEEF, 4'b1111, 32'h0, 1'b0, "st54");
    do_req(1'b0, 32'h54, 32'h0, 4'b1111, 32'hDEADBEEF, 1'b0, "ld54");

    // Partial lanes 0 and 2
    do_req(1'b1, 32'h54, 32'h11223344, 4'b0101, 32'h0, 1'b0, "st54_be5");
    do_req(1'b0, 32'h54, 32'h0, 4'b0000, 32'hDE22BE44, 1'b0, "ld54_be5");

    // be=0000 store is a legal no-op
    do_req(1'b1, 32'h54, 32'hFFFFFFFF, 4'b0000, 32'h0, 1'b0, "st54_be0");
    do_req(1'b0, 32'h54, 32'h0, 4'b1111, 32'hDE22BE44, 1'b0, "ld54_be0");

    // Response back-pressure with a second request waiting
    bus.rsp_ready = 1'b0;
    present(1'b0, 32'h54, 32'h0, 4'b1111, "ld_stall");
    exp_q.push_back('{rd: 32'hDE22BE44, err: 1'b0});
    wait_rsp("ld_stall");
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = 32'h54;
    bus.req_be    = 4'b1111;
    exp_q.push_back('{rd: 32'hDE22BE44, err: 1'b0});
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("stall_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("stall_rdata", bus.rsp_rdata, 32'hDE22BE44);
      chk("stall_err", 32'(bus.rsp_err), 32'd0);
      chk("stall_req_ready", 32'(bus.req_ready), 32'd0);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("hs_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("hs_req_ready", 32'(bus.req_ready), 32'd1);
    chk("hs_not_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    chk("second_accept_busy", 32'(busy), 32'd1);
    chk("second_accept_rdy", 32'(bus.req_ready), 32'd0);
    bus.req_valid = 1'b0;
    wait_rsp("ld_second");
    drain("ld_second");

    // Reset during WAIT aborts the store
    do_req(1'b1, 32'h10, 32'h12345678, 4'b1111, 32'h0, 1'b0, "st10");
    present(1'b1, 32'h10, 32'h0000CAFE, 4'b1111, "st10_abort");
    reset = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    chk("abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    do_req(1'b0, 32'h10, 32'h0, 4'b1111, 32'h12345678, 1'b0, "ld10");

    // Out of range: no write, no aliasing onto word 0
    do_req(1'b1, 32'h0, 32'hA5A5A5A5, 4'b1111, 32'h0, 1'b0, "st0");
    do_req(1'b1, 32'h100, 32'hFFFFFFFF, 4'b1111, 32'h0, 1'b1, "st100");
    do_req(1'b0, 32'h100, 32'h0, 4'b1111, 32'h0, 1'b1, "ld100");
    do_req(1'b0, 32'h0, 32'h0, 4'b1111, 32'hA5A5A5A5, 1'b0, "ld0");

    // Last in-range word
    do_req(1'b1, 32'hFC, 32'h0BADF00D, 4'b1111, 32'h0, 1'b0, "stFC");
    do_req(1'b0, 32'hFC, 32'h0, 4'b1111, 32'h0BADF00D, 1'b0, "ldFC");

    // Misaligned load
`ifdef DMEM_MISALIGN_ERR_EN
    do_req(1'b0, 32'h56, 32'h0, 4'b1111, 32'h0, 1'b1, "ld56");
`else
    do_req(1'b0, 32'h56, 32'h0, 4'b1111, 32'hDE22BE44, 1'b0, "ld56");
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
